// File: rtl/debouncer_pkg.sv
// Shared definitions for the delayed-output debouncer: FSM state encoding and
// the default qualification length.
`timescale 1ns/1ps
package debouncer_pkg;

  // 20 ms of stable input at a 100 MHz clock.
  localparam int unsigned STABLE_CYCLES_DEFAULT = 2_000_000;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } deb_state_e;

endpackage

// File: rtl/edge_detector.sv
// Turns a registered level into single-cycle rise/fall/any-change pulses.
`timescale 1ns/1ps
module edge_detector (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic p_edge,
  output logic n_edge,
  output logic any_edge
);

  logic level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_q <= 1'b0;
    else          level_q <= level;
  end

  assign p_edge   = level & ~level_q;
  assign n_edge   = ~level & level_q;
  assign any_edge = p_edge | n_edge;

endmodule

// File: rtl/debouncer_delayed.sv
// Button/switch debouncer: 2-flop synchronizer, four-state qualification FSM
// with a stability counter, and rise/fall pulses on the filtered level.
`timescale 1ns/1ps
module debouncer_delayed
  import debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy,
  output logic debounced,
  output logic p_edge,
  output logic n_edge,
  output logic any_edge
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_meta;
  logic             s;
  deb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             deb_nxt;

  // NOTE: every flop uses <= so all registers sample pre-edge values; blocking
  // assignments here would collapse the two synchronizer stages into one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
    end else begin
      sync_meta <= noisy;
      s         <= sync_meta;
    end
  end

  // NOTE: next-state values are defaulted to hold before the case, so no path
  // through the block leaves them unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ZERO: begin
        if (s) begin
          state_nxt = WAIT1;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_nxt = ZERO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      ONE: begin
        if (!s) begin
          state_nxt = WAIT0;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT0: begin
        if (s) begin
          state_nxt = ONE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ZERO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ZERO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output is registered from the next state so it moves on the same edge.
  assign deb_nxt = (state_nxt == ONE) || (state_nxt == WAIT0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ZERO;
      cnt       <= '0;
      debounced <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      debounced <= deb_nxt;
    end
  end

  edge_detector u_edge_detector (
    .clk      (clk),
    .reset_n  (reset_n),
    .level    (debounced),
    .p_edge   (p_edge),
    .n_edge   (n_edge),
    .any_edge (any_edge)
  );

endmodule

// File: tb/tb_debouncer_delayed.sv
// Self-checking bench for debouncer_delayed (STABLE_CYCLES=8): directed press,
// release, bounce, glitch and reset steps, then randomized levels and resets.
`timescale 1ns/1ps
module tb_debouncer_delayed;

  localparam int N = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic noisy   = 1'b0;
  logic debounced, p_edge, n_edge, any_edge;

  int n_cmp = 0;
  int n_bad = 0;
  int p_cnt, n_cnt;

  // Reference model: a two-sample input delay, then a run-length rule -- the
  // level flips once N consecutive samples disagree with it.
  bit m_sync1, m_sync2, m_deb, m_deb_prev;
  int m_run;

  debouncer_delayed #(.STABLE_CYCLES(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .noisy     (noisy),
    .debounced (debounced),
    .p_edge    (p_edge),
    .n_edge    (n_edge),
    .any_edge  (any_edge)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync1 = 0; m_sync2 = 0; m_deb = 0; m_deb_prev = 0; m_run = 0;
  endtask

  task automatic model_edge();
    m_deb_prev = m_deb;
    if (m_sync2 != m_deb) begin
      m_run++;
      if (m_run == N) begin
        m_deb = m_sync2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_sync2 = m_sync1;
    m_sync1 = noisy;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".debounced"}, debounced, m_deb);
    check({tag, ".p_edge"},    p_edge,    m_deb & ~m_deb_prev);
    check({tag, ".n_edge"},    n_edge,    ~m_deb & m_deb_prev);
    check({tag, ".any_edge"},  any_edge,  m_deb ^ m_deb_prev);
  endtask

  // Called at a falling edge: drive noisy, take one rising edge, check 1 ns later.
  task automatic cycle(input string tag, input logic val);
    noisy = val;
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_edge();
    #1;
    check_outputs(tag);
    if (p_edge) p_cnt++;
    if (n_edge) n_cnt++;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse launched between clock edges.
  task automatic pulse_reset(input string tag, input int low_cycles);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(negedge clk);
    for (int i = 0; i < low_cycles; i++) cycle({tag, ".held"}, noisy);
    reset_n = 1'b1;
  endtask

  // Holds a level and returns the edge number (capture edge = 1) at which
  // debounced first equals 'val', or 0 if it never does.
  task automatic hold(input string tag, input logic val, input int cycles, output int first);
    first = 0;
    for (int i = 1; i <= cycles; i++) begin
      cycle(tag, val);
      if (first == 0 && debounced === val) first = i;
    end
  endtask

  initial begin
    int first;
    model_reset();

    // Reset held with noisy high, then released with noisy low.
    @(negedge clk);
    p_cnt = 0; n_cnt = 0;
    for (int i = 0; i < 5; i++) cycle("rst_hold", 1'b1);
    noisy   = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) cycle("rst_release", 1'b0);
    check_int("rst_pulses", p_cnt + n_cnt, 0);

    // Clean press: rise on the (N+2)th edge counting the capture edge.
    p_cnt = 0; n_cnt = 0;
    hold("press", 1'b1, 50, first);
    check_int("press_latency", first, N + 2);
    check_int("press_p_count", p_cnt, 1);
    check_int("press_n_count", n_cnt, 0);

    // Clean release.
    p_cnt = 0; n_cnt = 0;
    hold("release", 1'b0, 50, first);
    check_int("release_latency", first, N + 2);
    check_int("release_p_count", p_cnt, 0);
    check_int("release_n_count", n_cnt, 1);

    // Bounce: five 5-cycle toggles ending high; only the final hold qualifies.
    p_cnt = 0; n_cnt = 0;
    for (int t = 0; t < 4; t++) hold("bounce", (t % 2 == 0), 5, first);
    hold("bounce_last", 1'b1, 30, first);
    check_int("bounce_latency", first, N + 2);
    check_int("bounce_p_count", p_cnt, 1);
    check_int("bounce_n_count", n_cnt, 0);

    // Glitch: N-1 low samples while high must not disturb the output.
    p_cnt = 0; n_cnt = 0;
    hold("glitch_low", 1'b0, N - 1, first);
    hold("glitch_high", 1'b1, 20, first);
    check("glitch_level", debounced, 1'b1);
    check_int("glitch_pulses", p_cnt + n_cnt, 0);

    // Reset in mid-qualification, then a fresh press from ZERO.
    hold("midq", 1'b0, 5, first);
    pulse_reset("midq_rst", 2);
    p_cnt = 0; n_cnt = 0;
    hold("midq_after", 1'b1, 30, first);
    check_int("midq_latency", first, N + 2);
    check_int("midq_p_count", p_cnt, 1);
    check_int("midq_n_count", n_cnt, 0);

    // Randomized levels and hold lengths straddling N, with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 2 * N + 4));
      if ($urandom_range(0, 39) == 0) pulse_reset("rand_rst", int'($urandom_range(1, 3)));
      hold("rand", lvl, len, first);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debouncer_delayed.md
DEBOUNCER_DELAYED -- requirements
Module: debouncer_delayed

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2_000_000 (20 ms at a 100 MHz clk); the number of consecutive stable synchronized samples required to change the output; legal range 2..2^24.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port noisy, input, 1 bit: the raw, asynchronous, bouncing button/switch signal.
REQ-005 SHALL have port debounced, output, 1 bit: the filtered level, driven directly from a register.
REQ-006 SHALL have port p_edge, output, 1 bit: a one-cycle pulse on each 0->1 transition of debounced.
REQ-007 SHALL have port n_edge, output, 1 bit: a one-cycle pulse on each 1->0 transition of debounced.
REQ-008 SHALL have port any_edge, output, 1 bit: p_edge OR n_edge.

Function
REQ-009 SHALL pass noisy through a 2-flop synchronizer; the second-flop output is called s.
REQ-010 SHALL implement a 4-state FSM: ZERO, WAIT1, ONE, WAIT0.
REQ-011 In ZERO, debounced SHALL be 0; s=1 SHALL load the counter with 1 and move to WAIT1.
REQ-012 In WAIT1, debounced SHALL be 0.
- s=0: return to ZERO and clear the counter.
- s=1 with counter=STABLE_CYCLES-1: move to ONE.
- otherwise: increment the counter.
REQ-013 In ONE, debounced SHALL be 1; s=0 SHALL load the counter with 1 and move to WAIT0.
REQ-014 In WAIT0, debounced SHALL be 1.
- s=1: return to ONE and clear the counter.
- s=0 with counter=STABLE_CYCLES-1: move to ZERO.
- otherwise: increment the counter.
REQ-015 debounced SHALL change exactly STABLE_CYCLES+2 rising clk edges after the first edge at which the synchronizer's first flop captures the new, thereafter stable, noisy level.
REQ-016 Any bounce shorter than STABLE_CYCLES samples SHALL leave debounced unchanged and restart qualification from zero.
REQ-017 The counter SHALL be $clog2(STABLE_CYCLES+1) bits wide, unsigned, and SHALL never wrap.
REQ-018 debounced SHALL be registered, updating on the same edge as the FSM state change.
REQ-019 p_edge SHALL equal debounced AND NOT debounced_q, where debounced_q is debounced delayed by one clk.
- p_edge is high for exactly the first cycle in which debounced=1.
REQ-020 n_edge SHALL equal NOT debounced AND debounced_q.
REQ-021 p_edge and n_edge SHALL never be high in the same cycle.
REQ-022 The edge outputs SHALL remain low while debounced holds a constant level.

Reset
REQ-023 Asserting reset_n low SHALL immediately, independent of clk, set:
- both synchronizer flops to 0,
- the state to ZERO,
- the counter to 0,
- debounced and debounced_q to 0, so p_edge, n_edge and any_edge are 0.
REQ-024 No edge pulse SHALL be generated on or after reset deassertion unless debounced later transitions.
REQ-025 Reset asserted mid-qualification (WAIT1/WAIT0) SHALL abandon the qualification; after release, the FSM restarts from ZERO.

Structure
REQ-026 The state encoding (ZERO, WAIT1, ONE, WAIT0) SHALL reside in a shared package debouncer_pkg, together with the default STABLE_CYCLES constant.
REQ-027 Edge detection SHALL be a separate sub-module, edge_detector, with ports clk, reset_n, level, p_edge, n_edge, any_edge, instantiated once on debounced.
REQ-028 The synchronizer, FSM and counter SHALL live in debouncer_delayed.

Verification (STABLE_CYCLES=8, clk 10 ns unless stated)
REQ-029 Reset: hold reset_n=0 with noisy=1 -> debounced=0 and all edges 0 throughout; release reset with noisy=0 -> no pulses.
REQ-030 Clean press: noisy 0->1 held 50 cycles -> debounced rises exactly 10 edges after capture; p_edge and any_edge high for 1 cycle; n_edge stays 0.
REQ-031 Clean release: noisy 1->0 held -> debounced falls after 10 edges; n_edge and any_edge high for 1 cycle.
REQ-032 Bounce rejection: noisy toggles every 5 cycles for 5 toggles, ending high, then held -> debounced rises only 10 edges after the last toggle capture; exactly one p_edge pulse.
REQ-033 Glitch rejection: with debounced=1, noisy low for 7 cycles then high -> debounced stays 1 and no edge pulses occur.
REQ-034 Long run at default parameter (100 MHz, 50 ms hold, 1.25 ms bounces) -> debounced follows each 25/50 ms stable level, with exactly one pulse per transition.
